// File: rtl/axi4lite_regfile_pkg.sv
// rtl/axi4lite_regfile_pkg.sv - shared constants for the AXI4-Lite 4x8 register file (option: REGFILE_RO_ID_EN)
package axi4lite_regfile_pkg;

    localparam int NUM_REGS = 4;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [7:0] ID_VALUE = 8'hA5;
    localparam logic [1:0] ID_IDX   = 2'd3;

`ifdef REGFILE_RO_ID_EN
    localparam bit RO_ID_EN   = 1'b1;
    localparam int NUM_STORED = NUM_REGS - 1;
`else
    localparam bit RO_ID_EN   = 1'b0;
    localparam int NUM_STORED = NUM_REGS;
`endif

    function automatic logic idx_writable(input logic [1:0] idx);
        return !(RO_ID_EN && (idx == ID_IDX));
    endfunction

endpackage

// File: rtl/axi4lite_regfile_slave_if.sv
// rtl/axi4lite_regfile_slave_if.sv - AXI4-Lite bus bundle between a master and the register file slave
interface axi4lite_regfile_slave_if;
    logic [1:0] s_axi_awaddr;
    logic       s_axi_awvalid;
    logic       s_axi_awready;
    logic [7:0] s_axi_wdata;
    logic       s_axi_wstrb;
    logic       s_axi_wvalid;
    logic       s_axi_wready;
    logic [1:0] s_axi_bresp;
    logic       s_axi_bvalid;
    logic       s_axi_bready;
    logic [1:0] s_axi_araddr;
    logic       s_axi_arvalid;
    logic       s_axi_arready;
    logic [7:0] s_axi_rdata;
    logic [1:0] s_axi_rresp;
    logic       s_axi_rvalid;
    logic       s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/regfile_4x8.sv
// rtl/regfile_4x8.sv - four 8-bit registers, one write port, combinational read (option: REGFILE_RO_ID_EN)
module regfile_4x8
    import axi4lite_regfile_pkg::*;
(
    input  logic        m_axi_aclk,
    input  logic        m_axi_aresetn,
    input  logic        i_wr_en,
    input  logic [1:0]  i_wr_idx,
    input  logic [7:0]  i_wr_data,
    input  logic [1:0]  i_rd_idx,
    output logic [7:0]  o_rd_data,
    output logic [31:0] o_reg_q
);
    logic [7:0] r_regs [NUM_STORED];
    logic [7:0] w_regs [NUM_REGS];

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            for (int i = 0; i < NUM_STORED; i++) r_regs[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_STORED; i++)
                if (i_wr_en && (i_wr_idx == 2'(i))) r_regs[i] <= i_wr_data;
        end
    end

    // With the ID option the top slot has no storage and reads the constant.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
        if (g < NUM_STORED) begin : g_stored
            assign w_regs[g] = r_regs[g];
        end else begin : g_const
            assign w_regs[g] = ID_VALUE;
        end
    end

    assign o_rd_data = w_regs[i_rd_idx];
    assign o_reg_q   = {w_regs[3], w_regs[2], w_regs[1], w_regs[0]};
endmodule

// File: rtl/axi4lite_regfile_slave.sv
// rtl/axi4lite_regfile_slave.sv - AXI4-Lite slave: independent write/read FSMs over regfile_4x8 (option: REGFILE_RO_ID_EN)
module axi4lite_regfile_slave
    import axi4lite_regfile_pkg::*;
(
    input  logic                           m_axi_aclk,
    input  logic                           m_axi_aresetn,
    axi4lite_regfile_slave_if.slave        s_axi,
    output logic [31:0]                    reg_q,
    output logic                           wr_strobe,
    output logic [1:0]                     wr_idx
);
    logic       r_rst_done;
    logic [1:0] r_wstate;
    logic [0:0] r_rstate;
    logic [1:0] r_waddr;
    logic [7:0] r_wdata;
    logic       r_wstrb;
    logic [1:0] r_bresp;
    logic [7:0] r_rdata;
    logic [1:0] r_rresp;
    logic       r_wr_strobe;
    logic [1:0] r_wr_idx;

    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_ar_hs;
    logic       w_commit;
    logic       w_wr_en;
    logic [1:0] w_cidx;
    logic [7:0] w_cdata;
    logic       w_cstrb;
    logic [7:0] w_rd_data;
    logic [1:0] w_next_wstate;

    // Readies come from state plus a registered reset-done flag only.
    assign s_axi.s_axi_awready = r_rst_done && ((r_wstate == W_IDLE) || (r_wstate == W_DATA));
    assign s_axi.s_axi_wready  = r_rst_done && ((r_wstate == W_IDLE) || (r_wstate == W_ADDR));
    assign s_axi.s_axi_arready = r_rst_done && (r_rstate == R_IDLE);
    assign s_axi.s_axi_bvalid  = (r_wstate == W_RESP);
    assign s_axi.s_axi_bresp   = r_bresp;
    assign s_axi.s_axi_rvalid  = (r_rstate == R_DATA);
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rresp   = r_rresp;

    assign w_aw_hs = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
    assign w_w_hs  = s_axi.s_axi_wvalid  && s_axi.s_axi_wready;
    assign w_ar_hs = s_axi.s_axi_arvalid && s_axi.s_axi_arready;

    always_comb begin
        w_next_wstate = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) w_next_wstate = W_RESP;
                else if (w_aw_hs)      w_next_wstate = W_ADDR;
                else if (w_w_hs)       w_next_wstate = W_DATA;
            end
            W_ADDR:  if (w_w_hs)  w_next_wstate = W_RESP;
            W_DATA:  if (w_aw_hs) w_next_wstate = W_RESP;
            W_RESP:  if (s_axi.s_axi_bready) w_next_wstate = W_IDLE;
            default: w_next_wstate = W_IDLE;
        endcase
    end

    // The half arriving on the commit edge comes from the bus, the other half from the hold registers.
    assign w_commit = (r_wstate != W_RESP) && (w_next_wstate == W_RESP);
    assign w_cidx   = w_aw_hs ? s_axi.s_axi_awaddr : r_waddr;
    assign w_cdata  = w_w_hs  ? s_axi.s_axi_wdata  : r_wdata;
    assign w_cstrb  = w_w_hs  ? s_axi.s_axi_wstrb  : r_wstrb;
    assign w_wr_en  = w_commit && w_cstrb && idx_writable(w_cidx);

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_rst_done  <= 1'b0;
            r_wstate    <= W_IDLE;
            r_waddr     <= 2'd0;
            r_wdata     <= 8'h00;
            r_wstrb     <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_wr_strobe <= 1'b0;
            r_wr_idx    <= 2'd0;
        end else begin
            r_rst_done  <= 1'b1;
            r_wstate    <= w_next_wstate;
            r_wr_strobe <= w_commit;
            if (w_aw_hs) r_waddr <= s_axi.s_axi_awaddr;
            if (w_w_hs) begin
                r_wdata <= s_axi.s_axi_wdata;
                r_wstrb <= s_axi.s_axi_wstrb;
            end
            if (w_commit) begin
                r_wr_idx <= w_cidx;
                r_bresp  <= idx_writable(w_cidx) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // rdata samples the pre-commit value when a write lands on the same edge.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_rstate <= R_IDLE;
            r_rdata  <= 8'h00;
            r_rresp  <= RESP_OKAY;
        end else if (r_rstate == R_IDLE) begin
            if (w_ar_hs) begin
                r_rstate <= R_DATA;
                r_rdata  <= w_rd_data;
                r_rresp  <= RESP_OKAY;
            end
        end else if (s_axi.s_axi_rready) begin
            r_rstate <= R_IDLE;
        end
    end

    regfile_4x8 u_regfile (
        .m_axi_aclk    (m_axi_aclk),
        .m_axi_aresetn (m_axi_aresetn),
        .i_wr_en       (w_wr_en),
        .i_wr_idx      (w_cidx),
        .i_wr_data     (w_cdata),
        .i_rd_idx      (s_axi.s_axi_araddr),
        .o_rd_data     (w_rd_data),
        .o_reg_q       (reg_q)
    );

    assign wr_strobe = r_wr_strobe;
    assign wr_idx    = r_wr_idx;
endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// tb/tb_axi4lite_regfile_slave.sv - self-checking bench for axi4lite_regfile_slave (honours REGFILE_RO_ID_EN)
module tb_axi4lite_regfile_slave;
`ifdef REGFILE_RO_ID_EN
    localparam bit RO = 1'b1;
`else
    localparam bit RO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] reg_q;
    logic        wr_strobe;
    logic [1:0]  wr_idx;

    axi4lite_regfile_slave_if bus ();

    axi4lite_regfile_slave dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (resetn),
        .s_axi         (bus),
        .reg_q         (reg_q),
        .wr_strobe     (wr_strobe),
        .wr_idx        (wr_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] mdl [4];

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        logic       strb;
        int         order;
        int         bdly;
        int         rdly;
        logic [1:0] bresp;
        logic [7:0] rdata;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdl_q();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    function automatic logic [1:0] exp_bresp(input logic [1:0] a);
        return (RO && a == 2'd3) ? 2'b10 : 2'b00;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
        if (RO) mdl[3] = 8'hA5;
    endtask

    task automatic mdl_write(input logic [1:0] a, input logic [7:0] d, input logic s);
        if (s && !(RO && a == 2'd3)) mdl[a] = d;
    endtask

    task automatic idle_bus();
        bus.s_axi_awaddr = 0; bus.s_axi_awvalid = 0; bus.s_axi_wdata = 0;
        bus.s_axi_wstrb = 0;  bus.s_axi_wvalid = 0;  bus.s_axi_bready = 0;
        bus.s_axi_araddr = 0; bus.s_axi_arvalid = 0; bus.s_axi_rready = 0;
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first
    task automatic do_write(input logic [1:0] a, input logic [7:0] d, input logic s,
                            input int order, input int bdly, input logic [1:0] eb);
        logic aw_done = 0, w_done = 0, aw_f, w_f;
        int cyc = 0;
        @(posedge clk); #1;
        bus.s_axi_awaddr = a; bus.s_axi_wdata = d; bus.s_axi_wstrb = s;
        bus.s_axi_awvalid = (order != 2);
        bus.s_axi_wvalid  = (order != 1);
        while (!(aw_done && w_done) && cyc < 20) begin
            @(negedge clk);
            check("bvalid_early", bus.s_axi_bvalid, 0);
            aw_f = bus.s_axi_awvalid && bus.s_axi_awready;
            w_f  = bus.s_axi_wvalid && bus.s_axi_wready;
            @(posedge clk); #1;
            if (aw_f) begin bus.s_axi_awvalid = 0; aw_done = 1; end
            if (w_f)  begin bus.s_axi_wvalid = 0;  w_done = 1;  end
            if (aw_done && !w_done) bus.s_axi_wvalid = 1;
            if (w_done && !aw_done) bus.s_axi_awvalid = 1;
            cyc++;
        end
        if (!(aw_done && w_done)) begin
            bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0;
            check("write_timeout", 0, 1);
            return;
        end
        mdl_write(a, d, s);
        @(negedge clk);
        check("wr_strobe", wr_strobe, 1);
        check("wr_idx", wr_idx, a);
        check("bvalid", bus.s_axi_bvalid, 1);
        check("bresp", bus.s_axi_bresp, eb);
        check("reg_q", reg_q, mdl_q());
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            check("bvalid_hold", bus.s_axi_bvalid, 1);
            check("bresp_hold", bus.s_axi_bresp, eb);
            check("aw_w_blocked", {bus.s_axi_awready, bus.s_axi_wready}, 0);
            check("wr_strobe_once", wr_strobe, 0);
        end
        bus.s_axi_bready = 1;
        @(posedge clk); #1 bus.s_axi_bready = 0;
        @(negedge clk);
        check("bvalid_clear", bus.s_axi_bvalid, 0);
    endtask

    task automatic do_read(input logic [1:0] a, input int rdly, input logic [7:0] ed);
        logic fired = 0;
        int cyc = 0;
        @(posedge clk); #1;
        bus.s_axi_araddr = a; bus.s_axi_arvalid = 1;
        while (!fired && cyc < 20) begin
            @(negedge clk);
            check("rvalid_early", bus.s_axi_rvalid, 0);
            fired = bus.s_axi_arvalid && bus.s_axi_arready;
            @(posedge clk); #1;
            cyc++;
        end
        bus.s_axi_arvalid = 0;
        if (!fired) begin check("read_timeout", 0, 1); return; end
        @(negedge clk);
        check("rvalid_latency", bus.s_axi_rvalid, 1);
        check("rdata", bus.s_axi_rdata, ed);
        check("rresp", bus.s_axi_rresp, 0);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check("rvalid_hold", bus.s_axi_rvalid, 1);
            check("rdata_hold", bus.s_axi_rdata, ed);
            check("ar_blocked", bus.s_axi_arready, 0);
        end
        bus.s_axi_rready = 1;
        @(posedge clk); #1 bus.s_axi_rready = 0;
        @(negedge clk);
        check("rvalid_clear", bus.s_axi_rvalid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] a;
        logic [7:0] d;
        logic       s;

        vecs[0] = '{2'd0, 8'hA1, 1'b1, 0, 0, 0, 2'b00, 8'hA1};
        vecs[1] = '{2'd1, 8'hB2, 1'b1, 1, 1, 2, 2'b00, 8'hB2};
        vecs[2] = '{2'd2, 8'hC3, 1'b1, 2, 0, 1, 2'b00, 8'hC3};
        vecs[3] = '{2'd3, 8'hD4, 1'b1, 0, 1, 1, (RO ? 2'b10 : 2'b00), (RO ? 8'hA5 : 8'hD4)};
        vecs[4] = '{2'd1, 8'h77, 1'b0, 2, 0, 0, 2'b00, 8'hB2};
        vecs[5] = '{2'd0, 8'h00, 1'b1, 1, 2, 0, 2'b00, 8'h00};

        idle_bus();
        resetn = 0;
        mdl_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 0);
        check("rst_valid", {bus.s_axi_bvalid, bus.s_axi_rvalid}, 0);
        check("rst_resp", {bus.s_axi_bresp, bus.s_axi_rresp}, 0);
        check("rst_rdata", bus.s_axi_rdata, 0);
        check("rst_strobe", {wr_strobe, wr_idx}, 0);
        check("rst_reg_q", reg_q, mdl_q());
        @(posedge clk); #1 resetn = 1;
        @(negedge clk);
        check("ready_first_cycle", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b000);
        @(negedge clk);
        check("ready_second_cycle", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);

        // wstrb=0 leaves r0 untouched but still strobes
        do_write(2'd0, 8'hFF, 1'b0, 1, 0, 2'b00);

        // same-edge commit and read of addr 0 returns the old value
        @(posedge clk); #1;
        bus.s_axi_awaddr = 0; bus.s_axi_wdata = 8'h11; bus.s_axi_wstrb = 1;
        bus.s_axi_awvalid = 1; bus.s_axi_wvalid = 1;
        bus.s_axi_araddr = 0; bus.s_axi_arvalid = 1;
        @(negedge clk);
        check("rw_same_ready", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);
        @(posedge clk); #1;
        bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0; bus.s_axi_arvalid = 0;
        mdl_write(2'd0, 8'h11, 1'b1);
        @(negedge clk);
        check("rw_same_rdata_old", bus.s_axi_rdata, 8'h00);
        check("rw_same_valids", {bus.s_axi_bvalid, bus.s_axi_rvalid, wr_strobe}, 3'b111);
        check("rw_same_reg_q", reg_q, mdl_q());
        bus.s_axi_bready = 1; bus.s_axi_rready = 1;
        @(posedge clk); #1;
        bus.s_axi_bready = 0; bus.s_axi_rready = 0;
        @(negedge clk);
        check("rw_same_clear", {bus.s_axi_bvalid, bus.s_axi_rvalid}, 0);
        do_read(2'd0, 0, 8'h11);

        do_write(2'd1, 8'h3C, 1'b1, 1, 0, 2'b00);
        check("reg_q_r1", reg_q[15:8], 8'h3C);
        do_read(2'd1, 0, 8'h3C);
        do_write(2'd2, 8'h55, 1'b1, 2, 0, 2'b00);
        check("reg_q_r2", reg_q[23:16], 8'h55);
        do_write(2'd0, 8'h9E, 1'b1, 0, 5, 2'b00);
        do_read(2'd0, 5, 8'h9E);
        do_write(2'd3, 8'h00, 1'b1, 0, 0, RO ? 2'b10 : 2'b00);
        do_read(2'd3, 0, RO ? 8'hA5 : 8'h00);
        check("reg_q_r3", reg_q[31:24], RO ? 8'hA5 : 8'h00);

        // reset while the write FSM holds an address: nothing may complete
        @(posedge clk); #1;
        bus.s_axi_awaddr = 2'd1; bus.s_axi_awvalid = 1;
        @(negedge clk);
        check("abort_aw_ready", bus.s_axi_awready, 1);
        @(posedge clk); #1;
        bus.s_axi_awvalid = 0;
        resetn = 0;
        mdl_reset();
        @(negedge clk);
        check("abort_in_reset", {bus.s_axi_bvalid, bus.s_axi_awready, wr_strobe}, 0);
        check("abort_reg_q", reg_q, mdl_q());
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        @(negedge clk);
        check("abort_ready_first", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 0);
        @(negedge clk);
        check("abort_ready_second", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);
        check("abort_no_resp", {bus.s_axi_bvalid, wr_strobe}, 0);
        do_write(2'd2, 8'h5A, 1'b1, 2, 0, 2'b00);

        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].order, vecs[i].bdly, vecs[i].bresp);
            do_read(vecs[i].addr, vecs[i].rdly, vecs[i].rdata);
        end

        for (int i = 0; i < 60; i++) begin
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 3), exp_bresp(a));
            else
                do_read(a, $urandom_range(0, 3), mdl[a]);
        end
        check("final_reg_q", reg_q, mdl_q());

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
